// File: rtl/block_function_stack.sv
// Return-address LIFO for the PC stage: CALL pushes PC+1/PC+2,
// RET pops, top-of-stack is held in a register for MUX_IN_4.
module block_function_stack #(
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 16,
    parameter int CNT_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] PC_IN,
    input  logic                  CTRL_PUSH,
    input  logic                  CTRL_POP,
    input  logic                  SEL_RET_OFFSET,
    output logic [ADDR_WIDTH-1:0] STACK_TOP_OUT,
    output logic [CNT_WIDTH-1:0]  STACK_COUNT,
    output logic                  STACK_EMPTY,
    output logic                  STACK_FULL,
    output logic                  STACK_OVERFLOW,
    output logic                  STACK_UNDERFLOW
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [IDX_W-1:0]      cnt_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  push_only;
    logic                  pop_only;
    logic                  push_pop;
    logic                  mem_we;

    assign ret_addr = PC_IN + (SEL_RET_OFFSET ? ADDR_WIDTH'(2)
                                              : ADDR_WIDTH'(1));

    assign STACK_EMPTY = (STACK_COUNT == '0);
    assign STACK_FULL  = (STACK_COUNT == CNT_WIDTH'(STACK_DEPTH));

    assign push_only = CTRL_PUSH && !CTRL_POP;
    assign pop_only  = CTRL_POP && !CTRL_PUSH;
    assign push_pop  = CTRL_PUSH && CTRL_POP;

    // Index arithmetic is modulo the array size; count never exceeds depth.
    assign cnt_idx = STACK_COUNT[IDX_W-1:0];
    assign rd_idx  = cnt_idx - IDX_W'(2);
    assign wr_idx  = (push_pop && !STACK_EMPTY) ? cnt_idx - IDX_W'(1)
                                                : cnt_idx;
    assign mem_we  = reset && CTRL_PUSH && (CTRL_POP || !STACK_FULL);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= ret_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            STACK_COUNT     <= '0;
            STACK_TOP_OUT   <= '0;
            STACK_OVERFLOW  <= 1'b0;
            STACK_UNDERFLOW <= 1'b0;
        end else begin
            unique case (1'b1)
                push_only: begin
                    if (STACK_FULL) begin
                        STACK_OVERFLOW <= 1'b1;
                    end else begin
                        STACK_TOP_OUT <= ret_addr;
                        STACK_COUNT   <= STACK_COUNT + CNT_WIDTH'(1);
                    end
                end
                pop_only: begin
                    if (STACK_EMPTY) begin
                        STACK_UNDERFLOW <= 1'b1;
                    end else if (STACK_COUNT == CNT_WIDTH'(1)) begin
                        STACK_COUNT   <= '0;
                        STACK_TOP_OUT <= '0;
                    end else begin
                        STACK_COUNT   <= STACK_COUNT - CNT_WIDTH'(1);
                        STACK_TOP_OUT <= mem[rd_idx];
                    end
                end
                push_pop: begin
                    // Tail call replaces the top; on empty it degrades to a push.
                    STACK_TOP_OUT <= ret_addr;
                    if (STACK_EMPTY) begin
                        STACK_COUNT     <= CNT_WIDTH'(1);
                        STACK_UNDERFLOW <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_function_stack.sv
// Directed self-checking bench for block_function_stack.
module tb_block_function_stack;

    localparam int AW = 12;
    localparam int DEPTH = 16;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          sel = 1'b0;
    logic [AW-1:0] top;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          udf;

    int n_checks = 0;
    int n_fails = 0;

    always #5 clk = ~clk;

    block_function_stack #(
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PC_IN          (pc_in),
        .CTRL_PUSH      (push),
        .CTRL_POP       (pop),
        .SEL_RET_OFFSET (sel),
        .STACK_TOP_OUT  (top),
        .STACK_COUNT    (count),
        .STACK_EMPTY    (empty),
        .STACK_FULL     (full),
        .STACK_OVERFLOW (ovf),
        .STACK_UNDERFLOW(udf)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_top,
                             input logic [31:0] e_cnt, input logic e_ovf,
                             input logic e_udf);
        check({tag, ".top"}, top, e_top);
        check({tag, ".count"}, count, e_cnt);
        check({tag, ".empty"}, empty, e_cnt == 0);
        check({tag, ".full"}, full, e_cnt == DEPTH);
        check({tag, ".ovf"}, ovf, e_ovf);
        check({tag, ".udf"}, udf, e_udf);
    endtask

    task automatic step(input logic p, input logic q, input logic [AW-1:0] pc,
                        input logic s);
        push = p;
        pop = q;
        pc_in = pc;
        sel = s;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low across edges
        repeat (3) @(posedge clk);
        #1;
        check_all("rst_hold", 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_rel", 0, 0, 0, 0);

        // Basic push/pop sequence
        step(1, 0, 12'h010, 0);
        check_all("push1", 12'h011, 1, 0, 0);
        step(1, 0, 12'h020, 1);
        check_all("push2", 12'h022, 2, 0, 0);
        step(1, 0, 12'h7FF, 0);
        check_all("push3", 12'h800, 3, 0, 0);
        step(0, 1, 12'h000, 0);
        check_all("pop1", 12'h022, 2, 0, 0);
        step(0, 1, 12'h000, 0);
        check_all("pop2", 12'h011, 1, 0, 0);
        step(0, 1, 12'h000, 0);
        check_all("pop3", 12'h000, 0, 0, 0);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, AW'(i), 0);
            check("fill.top", top, i + 1);
        end
        check_all("full", 12'h010, DEPTH, 0, 0);
        step(1, 0, 12'h010, 0);
        check_all("ovf", 12'h010, DEPTH, 1, 0);
        for (int k = 0; k < DEPTH; k++) begin
            check("drain.top", top, DEPTH - k);
            step(0, 1, 12'h000, 0);
            check("drain.cnt", count, DEPTH - 1 - k);
        end
        check_all("drained", 0, 0, 1, 0);

        // Underflow, then a legal push still works
        step(0, 1, 12'h000, 0);
        check_all("udf", 0, 0, 1, 1);
        step(1, 0, 12'h100, 1);
        check_all("udf_push", 12'h102, 1, 1, 1);
        step(0, 1, 12'h000, 0);
        check_all("udf_pop", 0, 0, 1, 1);

        // Tail call with count 2
        pulse_reset();
        check_all("rst2", 0, 0, 0, 0);
        step(1, 0, 12'h000, 0);
        step(1, 0, 12'h010, 0);
        check_all("tc_pre", 12'h011, 2, 0, 0);
        step(1, 1, 12'h0FF, 1);
        check_all("tc", 12'h101, 2, 0, 0);
        step(0, 1, 12'h000, 0);
        check_all("tc_pop", 12'h001, 1, 0, 0);
        step(0, 1, 12'h000, 0);
        check_all("tc_pop2", 12'h000, 0, 0, 0);

        // Push and pop together on empty stack
        step(1, 1, 12'h030, 0);
        check_all("pp_empty", 12'h031, 1, 0, 1);

        // Wraparound of the return address
        step(1, 0, 12'hFFF, 1);
        check_all("wrap", 12'h001, 2, 0, 1);
        step(0, 1, 12'h000, 0);
        check_all("wrap_pop", 12'h031, 1, 0, 1);

        // Asynchronous reset between edges during a push
        push = 1'b1;
        pc_in = 12'h123;
        #3;
        reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("rst_push", 0, 0, 0, 0);
        push = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_after", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/block_function_stack.md
# block_function_stack

Return-address stack for the PC/instruction stage. On a CALL it captures the current program counter plus the call-instruction length. On a RET it supplies the saved address on `STACK_TOP_OUT`, which is wired to `MUX_IN_4` (function_stack input) of the PC/instruction/argument block. Storage is a register-array LIFO with registered top-of-stack, occupancy count, and sticky overflow/underflow error flags for the controller.

## Interface
- `ADDR_WIDTH`, 12: width of PC values and stack entries.
- `STACK_DEPTH`, 16: number of entries; any integer ≥ 2.
- `CNT_WIDTH`, `$clog2(STACK_DEPTH+1)`: width of the occupancy count (derived; do not override).

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `PC_IN`, in, `ADDR_WIDTH`: current PC (`REG_PC_OUT` of the PC stage).
- `CTRL_PUSH`, in, 1: push `PC_IN` + offset this cycle (CALL).
- `CTRL_POP`, in, 1: pop the top entry this cycle (RET).
- `SEL_RET_OFFSET`, in, 1: 0 selects offset +1, 1 selects offset +2 (call with argument byte).
- `STACK_TOP_OUT`, out, `ADDR_WIDTH`: registered top-of-stack; feeds `MUX_IN_4`.
- `STACK_COUNT`, out, `CNT_WIDTH`: number of valid entries.
- `STACK_EMPTY`, out, 1: `STACK_COUNT` == 0.
- `STACK_FULL`, out, 1: `STACK_COUNT` == `STACK_DEPTH`.
- `STACK_OVERFLOW`, out, 1: sticky; set by a push attempted while full.
- `STACK_UNDERFLOW`, out, 1: sticky; set by a pop attempted while empty.

## Operation
- Return address: `RET_ADDR = PC_IN + (SEL_RET_OFFSET ? 2 : 1)`, computed modulo 2^`ADDR_WIDTH`. `0xFFF + 1` wraps to `0x000` with no flag.
- Storage:
  - `mem[0..STACK_DEPTH-1]` holds the entries.
  - `STACK_TOP_OUT` mirrors `mem[count-1]` as a register, so the read path has no memory access.
- Push only, not full:
  - `mem[count] <= RET_ADDR`, `STACK_TOP_OUT <= RET_ADDR`, `count <= count+1`.
- Push only, full:
  - No state change except `STACK_OVERFLOW <= 1`.
  - Entries are never overwritten.
- Pop only, `count` ≥ 2:
  - `count <= count-1`, `STACK_TOP_OUT <= mem[count-2]`.
- Pop only, `count` == 1:
  - `count <= 0`, `STACK_TOP_OUT <= 0`.
- Pop only, empty:
  - No state change except `STACK_UNDERFLOW <= 1`.
  - `STACK_TOP_OUT` stays 0.
- Push and pop together, not empty (tail call):
  - `mem[count-1] <= RET_ADDR`, `STACK_TOP_OUT <= RET_ADDR`, `count` unchanged.
  - No flag change, even when full.
- Push and pop together, empty:
  - Treated as a push; `count` becomes 1, `STACK_TOP_OUT <= RET_ADDR`.
  - `STACK_UNDERFLOW <= 1`.
- Error flags:
  - Cleared only by reset.
  - Once set, they do not block later legal operations.
- No operation: all state holds.
- Entries above `count` are don't-care and are not reset.

## Timing
- Reset (`reset` == 0, asynchronous): `count` = 0, `STACK_TOP_OUT` = 0, `STACK_EMPTY` = 1, `STACK_FULL` = 0, `STACK_OVERFLOW` = 0, `STACK_UNDERFLOW` = 0.
  - These values hold immediately while reset is low, including mid-operation; any push or pop in that cycle is lost.
  - Deassertion takes effect at the next rising edge of `clk`.
- Latency:
  - `STACK_TOP_OUT` and `STACK_COUNT` reflect a push or pop one cycle after the edge that samples the control.
  - `STACK_EMPTY` and `STACK_FULL` are decoded combinationally from the registered `count`, so they have the same timing.
- RET protocol:
  - In the cycle the controller asserts `CTRL_POP`, it also drives `SEL_MUX` = 2'b11 with `CTRL_REG_PC` = 1.
  - `REG_PC_OUT` captures the pre-pop `STACK_TOP_OUT` on the same edge that removes the entry.
  - Zero-cycle penalty.
- CALL protocol:
  - `CTRL_PUSH` is asserted in the cycle where `PC_IN` still holds the CALL address, i.e. the same edge `REG_PC_OUT` loads the jump target.
  - `PC_IN` is sampled before that update.
- Back-to-back pushes and pops every cycle are supported with no bubbles.
- Flags become visible the cycle after the offending edge.

## Test plan
- Reset, then hold `reset` low: all outputs 0, `STACK_EMPTY` = 1. Release reset: outputs unchanged until the first control.
- Push with `PC_IN` = `0x010`/`SEL_RET_OFFSET` = 0, then `0x020`/1, then `0x7FF`/0, then pop ×3:
  - `STACK_TOP_OUT` sequence `0x011`, `0x022`, `0x800`, then `0x022`, `0x011`, `0x000`.
  - `STACK_COUNT` sequence 1, 2, 3, 2, 1, 0.
  - No flags set.
- Push `STACK_DEPTH`+1 times with `PC_IN` = i:
  - `STACK_FULL` = 1 after 16 pushes and `STACK_OVERFLOW` = 1 after the 17th.
  - Top stays `0x010`; popping 16 times returns 16, 15, …, 1.
- Pop on an empty stack: `STACK_UNDERFLOW` = 1, `count` = 0, top = 0.
  - A subsequent push of `0x100`/1 gives top `0x102` with the flag still 1.
- Simultaneous push and pop, first with `count` = 2 (top `0x011`) and `PC_IN` = `0x0FF`/1, then on an empty stack:
  - `count` = 2: top becomes `0x101`, `count` stays 2, and a later pop exposes the original bottom.
  - Empty stack: `count` becomes 1 and `STACK_UNDERFLOW` = 1.
- Wrap and reset:
  - Push with `PC_IN` = `0xFFF`/1: top = `0x001`.
  - Assert `reset` asynchronously mid-push between edges: outputs clear at once and the push is lost.
